// File: rtl/mcycle_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mcycle_pkg
//  Description : Shared definitions for the multi-cycle multiply/divide unit:
//                MCycleOp field encodings, FSM state type and the ALUFlags
//                bit positions common with the single-cycle ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
package mcycle_pkg;

    // MCycleOp fields: bit 1 picks the operation, bit 0 picks signedness
    localparam int   OP_TYPE_BIT   = 1;
    localparam int   OP_SIGNED_BIT = 0;
    localparam logic OP_MUL        = 1'b0;
    localparam logic OP_DIV        = 1'b1;

    // Iteration control states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } mcycle_state_t;

    // ALUFlags layout {N, Z, C, V}; this unit reports DivByZero in the V slot
    localparam int FLAG_N   = 3;
    localparam int FLAG_Z   = 2;
    localparam int FLAG_C   = 1;
    localparam int FLAG_DBZ = 0;

endpackage
`default_nettype wire

// File: rtl/mcycle_negate.sv
`default_nettype none
// ============================================================================
//  Module      : mcycle_negate
//  Description : Conditional two's-complement negation of a WIDTH-bit value.
//                Used for operand absolute values and result sign fix-up.
//  Revision    : 1.0 - initial release
// ============================================================================
module mcycle_negate
    import mcycle_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    assign o_data = i_en ? (~i_data + c_one) : i_data;

endmodule
`default_nettype wire

// File: rtl/mcycle_alu.sv
`default_nettype none
// ============================================================================
//  Module      : mcycle_alu
//  Description : Multi-cycle multiply (2*WIDTH product) and divide (quotient
//                and remainder), one bit per cycle, WIDTH+1 cycle latency.
//                Signed support is built only when MCYCLE_SIGNED_EN is
//                defined; otherwise MCycleOp[0] is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module mcycle_alu
    import mcycle_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRESET,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done,
    output logic [3:0]       ALUFlags
);

    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] c_last    = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    mcycle_state_t      r_state;
    logic [CNT_W-1:0]   r_count;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result1;
    logic [WIDTH-1:0]   r_result2;
    logic [3:0]         r_flags;

    // Working registers: r_hi:r_lo is the product accumulator for multiply,
    // remainder:dividend-shifting-into-quotient for divide.
    logic               r_is_div;
    logic               r_div0;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_dvd_raw;

    logic               w_accept;
    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_hi_n;
    logic [WIDTH-1:0]   w_lo_n;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_res1;
    logic [WIDTH-1:0]   w_res2;
    logic [3:0]         w_flags;

    // A request is taken in IDLE or DONE; Start during COMPUTE is dropped
    assign w_accept = Start && (r_state != COMPUTE);

`ifdef MCYCLE_SIGNED_EN
    logic w_is_signed;
    logic r_neg_res;
    logic r_neg_rem;

    assign w_is_signed = MCycleOp[OP_SIGNED_BIT];

    // Remember which results need negating once the magnitudes are done
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_neg_res <= w_is_signed & (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]);
            r_neg_rem <= w_is_signed & Operand1[WIDTH-1];
        end
    end

    mcycle_negate #(.WIDTH(WIDTH)) u_abs1 (
        .i_en   (w_is_signed & Operand1[WIDTH-1]),
        .i_data (Operand1),
        .o_data (w_abs1)
    );

    mcycle_negate #(.WIDTH(WIDTH)) u_abs2 (
        .i_en   (w_is_signed & Operand2[WIDTH-1]),
        .i_data (Operand2),
        .o_data (w_abs2)
    );

    mcycle_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
        .i_en   (r_neg_res),
        .i_data ({w_hi_n, w_lo_n}),
        .o_data (w_prod_fix)
    );

    mcycle_negate #(.WIDTH(WIDTH)) u_fix_quo (
        .i_en   (r_neg_res),
        .i_data (w_lo_n),
        .o_data (w_quo_fix)
    );

    mcycle_negate #(.WIDTH(WIDTH)) u_fix_rem (
        .i_en   (r_neg_rem),
        .i_data (w_hi_n),
        .o_data (w_rem_fix)
    );
`else
    logic w_unused_sign;

    assign w_unused_sign = MCycleOp[OP_SIGNED_BIT];
    assign w_abs1        = Operand1;
    assign w_abs2        = Operand2;
    assign w_prod_fix    = {w_hi_n, w_lo_n};
    assign w_quo_fix     = w_lo_n;
    assign w_rem_fix     = w_hi_n;
`endif

    // One shift-add (multiply) or restoring-subtract (divide) step
    always_comb begin
        w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
        w_shift   = {r_hi, r_lo[WIDTH-1]};
        w_ge      = (w_shift >= {1'b0, r_b});
        w_diff    = w_shift[WIDTH-1:0] - r_b;
        if (r_is_div) begin
            w_hi_n = w_ge ? w_diff : w_shift[WIDTH-1:0];
            w_lo_n = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            w_hi_n = w_mul_sum[WIDTH:1];
            w_lo_n = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    // Final result selection, including divide-by-zero override, and flags
    always_comb begin
        if (r_is_div) begin
            w_res1 = r_div0 ? '1        : w_quo_fix;
            w_res2 = r_div0 ? r_dvd_raw : w_rem_fix;
        end else begin
            w_res1 = w_prod_fix[WIDTH-1:0];
            w_res2 = w_prod_fix[2*WIDTH-1:WIDTH];
        end
        w_flags           = '0;
        w_flags[FLAG_N]   = w_res1[WIDTH-1];
        w_flags[FLAG_Z]   = (w_res1 == '0) && (w_res2 == '0);
        w_flags[FLAG_DBZ] = r_is_div & r_div0;
    end

    // Operand capture on an accepted request, then one step per COMPUTE cycle
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_is_div  <= (MCycleOp[OP_TYPE_BIT] == OP_DIV);
            r_div0    <= (Operand2 == '0);
            r_dvd_raw <= Operand1;
            r_a       <= w_abs1;
            r_b       <= w_abs2;
            r_hi      <= '0;
            r_lo      <= (MCycleOp[OP_TYPE_BIT] == OP_DIV) ? w_abs1 : w_abs2;
        end else if (r_state == COMPUTE) begin
            r_hi <= w_hi_n;
            r_lo <= w_lo_n;
        end
    end

    // Control FSM with registered Busy/Done/results/flags
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result1 <= '0;
            r_result2 <= '0;
            r_flags   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (Start) begin
                        r_state <= COMPUTE;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                COMPUTE: begin
                    r_count <= r_count + c_cnt_one;
                    if (r_count == c_last) begin
                        r_state   <= DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_result1 <= w_res1;
                        r_result2 <= w_res2;
                        r_flags   <= w_flags;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Result1  = r_result1;
    assign Result2  = r_result2;
    assign Busy     = r_busy;
    assign Done     = r_done;
    assign ALUFlags = r_flags;

endmodule
`default_nettype wire
